// File: rtl/shared_track_arbiter.sv
// shared_track_arbiter
//   Grants shared track 2 to one of two trains (A on track 1, B on track 3).
//   It sets the switches, waits for them to settle, then lets the owner move.
//   All outputs are Moore and registered.
//
// Ports
//   Clock               sole clock, rising edge
//   reset               asynchronous, active-low
//   ReqA / ReqB         level: train waiting at its entry sensor
//   ExitA / ExitB       one-cycle pulse: train has cleared track 2
//   SW1, SW2, SW3       switch drives (SW1=SW2=0 -> track 1, =1 -> track 3)
//   DA1,DA0 / DB1,DB0   train drive code, 01 forward, 00 stop
//   Owner               01 A, 10 B, 00 none
//   Fault               watchdog fault flag
//
// Build option
//   SHARED_TRACK_WDOG_EN  adds the run-time watchdog and the FAULT state.
//                         Without it Fault is tied low and a run never times out.
module shared_track_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       ExitA,
  input  logic       ExitB,
  output logic       SW1,
  output logic       SW2,
  output logic       SW3,
  output logic       DA1,
  output logic       DA0,
  output logic       DB1,
  output logic       DB0,
  output logic [1:0] Owner,
  output logic       Fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_A = 3'd1,
    RUN_A   = 3'd2,
    GRANT_B = 3'd3,
`ifdef SHARED_TRACK_WDOG_EN
    RUN_B   = 3'd4,
    FAULT   = 3'd5
`else
    RUN_B   = 3'd4
`endif
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef SHARED_TRACK_WDOG_EN
  localparam logic [CNT_W-1:0] RUN_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] RUN_LOAD    = '0;
`endif
  localparam logic [1:0] DRV_FWD  = 2'b01;
  localparam logic [1:0] DRV_STOP = 2'b00;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  // Reject parameter values that would make the counter loads meaningless.
  if (SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0 || CNT_W == 0) begin : g_bad_param
    $error("shared_track_arbiter: SETTLE_CYCLES, TIMEOUT_CYCLES and CNT_W must be non-zero");
  end

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             prio_a_q, prio_a_d;   // 1: A wins a simultaneous request
  logic             sw12_q,   sw12_d;
  logic [1:0]       da_q,     da_d;
  logic [1:0]       db_q,     db_d;
  logic [1:0]       owner_q,  owner_d;
  logic             fault_q,  fault_d;

  // Next state, settle/watchdog counter and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_a_d = prio_a_q;
    case (state_q)
      IDLE: begin
        if (ReqA && (!ReqB || prio_a_q)) begin
          state_d = GRANT_A;
          cnt_d   = SETTLE_LOAD;
        end else if (ReqB) begin
          state_d = GRANT_B;
          cnt_d   = SETTLE_LOAD;
        end
      end
      GRANT_A: begin
        if (cnt_q == '0) begin
          state_d = RUN_A;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GRANT_B: begin
        if (cnt_q == '0) begin
          state_d = RUN_B;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Exit has priority over a watchdog expiry in the same cycle.
      RUN_A: begin
        if (ExitA) begin
          prio_a_d = 1'b0;
          if (ReqB) begin
            state_d = GRANT_B;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`ifdef SHARED_TRACK_WDOG_EN
        else if (cnt_q == '0) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      RUN_B: begin
        if (ExitB) begin
          prio_a_d = 1'b1;
          if (ReqA) begin
            state_d = GRANT_A;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`ifdef SHARED_TRACK_WDOG_EN
        else if (cnt_q == '0) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
`ifdef SHARED_TRACK_WDOG_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered; a non-owner stops while it requests.
    sw12_d  = sw12_q;
    da_d    = ReqA ? DRV_STOP : DRV_FWD;
    db_d    = ReqB ? DRV_STOP : DRV_FWD;
    owner_d = OWN_NONE;
    fault_d = 1'b0;
    case (state_d)
      GRANT_A: begin
        sw12_d  = 1'b0;
        da_d    = DRV_STOP;
        db_d    = DRV_STOP;
        owner_d = OWN_A;
      end
      RUN_A: begin
        sw12_d  = 1'b0;
        da_d    = DRV_FWD;
        owner_d = OWN_A;
      end
      GRANT_B: begin
        sw12_d  = 1'b1;
        da_d    = DRV_STOP;
        db_d    = DRV_STOP;
        owner_d = OWN_B;
      end
      RUN_B: begin
        sw12_d  = 1'b1;
        db_d    = DRV_FWD;
        owner_d = OWN_B;
      end
`ifdef SHARED_TRACK_WDOG_EN
      FAULT: begin
        da_d    = DRV_STOP;
        db_d    = DRV_STOP;
        fault_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_a_q <= 1'b1;
      sw12_q   <= 1'b1;
      da_q     <= DRV_FWD;
      db_q     <= DRV_FWD;
      owner_q  <= OWN_NONE;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_a_q <= prio_a_d;
      sw12_q   <= sw12_d;
      da_q     <= da_d;
      db_q     <= db_d;
      owner_q  <= owner_d;
      fault_q  <= fault_d;
    end
  end

  assign SW1        = sw12_q;
  assign SW2        = sw12_q;
  assign SW3        = 1'b0;
  assign {DA1, DA0} = da_q;
  assign {DB1, DB0} = db_q;
  assign Owner      = owner_q;
`ifdef SHARED_TRACK_WDOG_EN
  assign Fault      = fault_q;
`else
  assign Fault      = 1'b0;
  // fault_q is always 0 here; keep it referenced so the register set is uniform.
  logic unused_fault;
  assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_shared_track_arbiter.sv
// Directed bench for shared_track_arbiter. Stimulus pushes expected outputs
// (tagged with the cycle they apply to) into a scoreboard queue; monitors
// pop and compare. Output vector layout: {Owner, SW1, SW2, SW3, DA, DB, Fault}.
module tb_shared_track_arbiter;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       ReqA  = 1'b0;
  logic       ReqB  = 1'b0;
  logic       ExitA = 1'b0;
  logic       ExitB = 1'b0;
  logic       SW1, SW2, SW3, DA1, DA0, DB1, DB0, Fault;
  logic [1:0] Owner;

  shared_track_arbiter #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (16)
  ) dut (
    .Clock(Clock), .reset(reset),
    .ReqA(ReqA), .ReqB(ReqB), .ExitA(ExitA), .ExitB(ExitB),
    .SW1(SW1), .SW2(SW2), .SW3(SW3),
    .DA1(DA1), .DA0(DA0), .DB1(DB1), .DB0(DB0),
    .Owner(Owner), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         exp_cyc_q[$];
  logic [9:0] exp_val_q[$];
  string      exp_name_q[$];
  logic [9:0] async_val_q[$];
  string      async_name_q[$];
  event       async_ev;

  function automatic logic [9:0] ev(input logic [1:0] own, input logic sw,
                                    input logic [1:0] da, input logic [1:0] db,
                                    input logic f);
    return {own, sw, sw, 1'b0, da, db, f};
  endfunction

  function automatic logic [9:0] act();
    return {Owner, SW1, SW2, SW3, DA1, DA0, DB1, DB0, Fault};
  endfunction

  function automatic void compare(input logic [9:0] got, input logic [9:0] want,
                                  input string name);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b want %b (own,sw1,sw2,sw3,da,db,fault)",
               name, cyc, got, want);
    end
  endfunction

  // Clocked monitor: one expectation per cycle at most, sampled 1 after the edge.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        void'(exp_cyc_q.pop_front());
        compare(act(), exp_val_q.pop_front(), exp_name_q.pop_front());
      end
    end
  end

  // Asynchronous monitor for checks made between clock edges.
  initial begin
    forever begin
      @(async_ev);
      while (async_val_q.size() > 0)
        compare(act(), async_val_q.pop_front(), async_name_q.pop_front());
    end
  end

  task automatic drive(input logic rst, input logic ra, input logic rb,
                       input logic ea, input logic eb);
    @(negedge Clock);
    reset = rst; ReqA = ra; ReqB = rb; ExitA = ea; ExitB = eb;
  endtask

  task automatic expect_next(input logic [9:0] v, input string name);
    exp_cyc_q.push_back(cyc + 1);
    exp_val_q.push_back(v);
    exp_name_q.push_back(name);
  endtask

  task automatic expect_now(input logic [9:0] v, input string name);
    async_val_q.push_back(v);
    async_name_q.push_back(name);
    -> async_ev;
  endtask

  logic [9:0] RST, GA, GB, RA, RA_BH, RB, RB_AH, IDLE_A, FLT;

  initial begin
    RST    = ev(2'b00, 1'b1, 2'b01, 2'b01, 1'b0);
    GA     = ev(2'b01, 1'b0, 2'b00, 2'b00, 1'b0);
    GB     = ev(2'b10, 1'b1, 2'b00, 2'b00, 1'b0);
    RA     = ev(2'b01, 1'b0, 2'b01, 2'b01, 1'b0);
    RA_BH  = ev(2'b01, 1'b0, 2'b01, 2'b00, 1'b0);
    RB     = ev(2'b10, 1'b1, 2'b01, 2'b01, 1'b0);
    RB_AH  = ev(2'b10, 1'b1, 2'b00, 2'b01, 1'b0);
    IDLE_A = ev(2'b00, 1'b0, 2'b01, 2'b01, 1'b0);
    FLT    = ev(2'b00, 1'b0, 2'b00, 2'b00, 1'b1);

    // Reset takes effect before any clock edge.
    #1 reset = 1'b0;
    #1 expect_now(RST, "reset_async");
    drive(0, 0, 0, 0, 0); expect_next(RST, "reset_hold");
    drive(1, 0, 0, 0, 0); expect_next(RST, "idle_after_reset");

    // Simultaneous requests after reset: A first, then B straight from RUN_A.
    drive(1, 1, 1, 0, 0); expect_next(GA, "both_req_grant_a");
    for (int i = 1; i < SETTLE; i++) begin
      drive(1, 1, 1, 0, 0); expect_next(GA, "grant_a_settle");
    end
    drive(1, 1, 1, 0, 0); expect_next(RA_BH, "run_a_b_held");
    drive(1, 0, 1, 0, 0); expect_next(RA_BH, "run_a_owner_req_drop");
    drive(1, 0, 1, 1, 0); expect_next(GB, "exit_a_to_grant_b");
    for (int i = 1; i < SETTLE; i++) begin
      drive(1, 0, 1, 0, 0); expect_next(GB, "grant_b_settle");
    end
    drive(1, 0, 1, 0, 0); expect_next(RB, "run_b_moves");

    // Foreign exit and owner's own request are ignored while B runs.
    drive(1, 0, 1, 1, 0); expect_next(RB, "run_b_ignore_exit_a");
    drive(1, 0, 0, 0, 0); expect_next(RB, "run_b_ignore_reqb_low");
    drive(1, 0, 1, 0, 0); expect_next(RB, "run_b_ignore_reqb_high");
    drive(1, 1, 1, 0, 0); expect_next(RB_AH, "run_b_hold_a");
    drive(1, 1, 0, 0, 1); expect_next(GA, "exit_b_to_grant_a");
    drive(1, 1, 0, 1, 0); expect_next(GA, "grant_a_ignore_exit");
    drive(1, 1, 0, 0, 0); expect_next(GA, "grant_a_settle_2");
    drive(1, 1, 0, 0, 0); expect_next(GA, "grant_a_settle_3");
    drive(1, 0, 0, 0, 0); expect_next(RA, "run_a_on_time");
    drive(1, 0, 0, 1, 0); expect_next(IDLE_A, "exit_a_to_idle");

    // A owned last, so a tie now goes to B.
    drive(1, 1, 1, 0, 0); expect_next(GB, "rr_grants_b");
    drive(1, 1, 1, 0, 0); expect_next(GB, "grant_b_settle_rr");

    // Reset in the middle of GRANT_B, then restart with only A requesting.
    @(negedge Clock);
    #2 reset = 1'b0;
    #1 expect_now(RST, "reset_mid_grant_b");
    drive(0, 1, 1, 0, 0); expect_next(RST, "reset_hold_2");
    drive(1, 1, 0, 0, 0); expect_next(GA, "restart_grant_a");
    for (int i = 1; i < SETTLE; i++) begin
      drive(1, 0, 0, 0, 0); expect_next(GA, "restart_settle");
    end

`ifdef SHARED_TRACK_WDOG_EN
    // Run without exit: TIMEOUT cycles in RUN_A, then FAULT which sticks.
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, 0, 0); expect_next(RA, "wdog_run_a");
    end
    drive(1, 0, 0, 0, 0); expect_next(FLT, "wdog_fault");
    drive(1, 1, 1, 1, 1); expect_next(FLT, "fault_sticky");
    drive(1, 0, 0, 0, 0); expect_next(FLT, "fault_sticky_2");
    drive(0, 0, 0, 0, 0); expect_next(RST, "fault_cleared_by_reset");
    drive(1, 1, 0, 0, 0); expect_next(GA, "wdog2_grant_a");
    for (int i = 1; i < SETTLE; i++) begin
      drive(1, 0, 0, 0, 0); expect_next(GA, "wdog2_settle");
    end
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, 0, 0); expect_next(RA, "wdog2_run_a");
    end
    drive(1, 0, 0, 1, 0); expect_next(IDLE_A, "exit_at_expiry");
    drive(1, 0, 0, 0, 0); expect_next(IDLE_A, "idle_after_expiry");
`else
    // No watchdog: RUN_A holds indefinitely until ExitA.
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      drive(1, 0, 0, 0, 0); expect_next(RA, "run_a_no_timeout");
    end
    drive(1, 0, 0, 1, 0); expect_next(IDLE_A, "exit_after_long_run");
`endif

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(posedge Clock);
    #2;
    n_vec++;
    if (exp_cyc_q.size() != 0 || async_val_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d clocked / %0d async expectations left, want 0",
               exp_cyc_q.size(), async_val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_track_arbiter.md
SHARED_TRACK_ARBITER -- requirements
Module: shared_track_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles switches are held before the granted train moves (1..2^CNT_W-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum cycles a train may own shared track 2 (used only with REQ-028).
REQ-003 SHALL have parameter CNT_W, default 16: width of the internal settle/watchdog counter.
REQ-004 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ReqA  input  1  level; train A is waiting at entry sensor S1 of track 1.
REQ-007 SHALL have port ReqB  input  1  level; train B is waiting at entry sensor S2 of track 3.
REQ-008 SHALL have port ExitA  input  1  one-cycle pulse; train A has cleared shared track 2 (sensor S4).
REQ-009 SHALL have port ExitB  input  1  one-cycle pulse; train B has cleared shared track 2 (sensor S3).
REQ-010 SHALL have port SW1, SW2, SW3  output  1 each  switch drives; SW1=SW2=0 routes track 1 onto track 2, SW1=SW2=1 routes track 3 onto track 2.
REQ-011 SHALL have port DA1, DA0, DB1, DB0  output  1 each  train A/B drive code; {D1,D0}=01 forward, 00 stop.
REQ-012 SHALL have port Owner  output  2  01 = A owns track 2, 10 = B owns, 00 = none.
REQ-013 SHALL have port Fault  output  1  watchdog fault flag.

Function
REQ-014 SHALL implement states IDLE, GRANT_A, RUN_A, GRANT_B, RUN_B, FAULT; all outputs registered (Moore).
REQ-015 IDLE: ReqA only -> GRANT_A; ReqB only -> GRANT_B; both -> grant the train that did not own last (round-robin pointer, A after reset).
REQ-016 GRANT_x SHALL set switches for x, hold both trains at stop, load counter with SETTLE_CYCLES-1, and go to RUN_x when counter reaches 0 (x moves exactly SETTLE_CYCLES cycles after grant entry).
REQ-017 RUN_A: SW1=SW2=0, DA=01; RUN_B: SW1=SW2=1, DB=01; SW3=0 in all states.
REQ-018 Non-owning train SHALL be driven 00 while its Req is high and 01 when its Req is low (still on its private track); hold takes effect in the cycle after Req is sampled.
REQ-019 RUN_x on Exit_x: if the other train's Req is high -> GRANT_other directly, else -> IDLE; round-robin pointer updates to x.
REQ-020 Exit pulse from the non-owning train, or any Exit in IDLE/GRANT states, SHALL be ignored.
REQ-021 Req of the owning train during RUN_x SHALL be ignored (no re-grant until Exit_x).
REQ-022 Owner SHALL be 01 in GRANT_A/RUN_A, 10 in GRANT_B/RUN_B, 00 otherwise.
REQ-023 Counter SHALL not wrap; it saturates at 0.

Reset
REQ-024 reset low SHALL immediately force IDLE, pointer=A, counter=0, Owner=00, Fault=0, SW1=SW2=1, SW3=0, DA=DB=01.
REQ-025 Reset asserted mid-GRANT or mid-RUN SHALL abandon the grant; after release, arbitration restarts from IDLE on the next edge.
REQ-026 Release of reset SHALL take effect at the first rising Clock edge after deassertion.

Configuration
REQ-027 Macro SHARED_TRACK_WDOG_EN SHALL compile in the watchdog.
REQ-028 With SHARED_TRACK_WDOG_EN: counter loads TIMEOUT_CYCLES-1 on RUN_x entry; reaching 0 without Exit_x -> FAULT; Exit_x in the same cycle as expiry wins; FAULT drives DA=DB=00, Fault=1, switches frozen, and is left only by reset.
REQ-029 Without SHARED_TRACK_WDOG_EN: no FAULT state, Fault tied to 0, RUN_x waits indefinitely for Exit_x.

Verification
REQ-030 ReqA=1 alone from IDLE -> Owner=01 next cycle, SW1=SW2=0, DA=00 for 4 cycles, then DA=01.
REQ-031 ReqA=ReqB=1 same cycle after reset -> A granted; ExitA pulse -> GRANT_B directly, Owner=10, DB=01 after 4 cycles.
REQ-032 RUN_B, ExitA pulse and ReqB toggles -> no state change, Owner stays 10.
REQ-033 Watchdog build, TIMEOUT_CYCLES=8, RUN_A with no ExitA -> Fault=1 on cycle 8, DA=DB=00; ExitA on cycle 8 instead -> IDLE, Fault=0.
REQ-034 reset low during GRANT_B -> outputs at reset values asynchronously (before next edge); after release with ReqA=1 -> GRANT_A.
